// File: rtl/mem_pkg.sv
// Shared memory-subsystem types and constants used by the SDRAM arbiter.
package mem_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

    localparam int BURST_WORDS = 16;
    localparam int SDRAM_ADDR_W = 26;
    localparam logic [SDRAM_ADDR_W-1:0] FRAME_BUFFER_START = 26'h3f80000;
endpackage

// File: rtl/rr_picker.sv
// Round-robin selector over the low-priority ports 1..NUM_PORTS-1.
module rr_picker
    import mem_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int PTR_W = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:1] request,
    input  logic [PTR_W-1:0]     rr_ptr,
    output logic [NUM_PORTS-1:1] grant,
    output logic                 valid
);
    logic [PTR_W-1:0] idx;

    // Scan starting at rr_ptr, wrapping within 1..NUM_PORTS-1; first hit wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_PORTS - 1; k++) begin
            idx = PTR_W'(((int'(rr_ptr) - 1 + k) % (NUM_PORTS - 1)) + 1);
            if (!valid && request[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates the SDRAM controller port: port 0 (VGA) has absolute priority,
// the remaining ports are served round-robin.
module sdram_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W = SDRAM_ADDR_W
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_PORTS-1:0]              p_request,
    output logic [NUM_PORTS-1:0]              p_ready,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  p_address,
    input  logic [NUM_PORTS-1:0]              p_write,
    input  logic [NUM_PORTS-1:0]              p_burst,
    input  logic [NUM_PORTS-1:0][31:0]        p_wdata,
    input  logic [NUM_PORTS-1:0][3:0]         p_wmask,
    output logic [NUM_PORTS-1:0]              p_rvalid,
    output logic [31:0]                       p_rdata,
    output logic [NUM_PORTS-1:0]              p_complete,
    output logic                              s_request,
    output logic [ADDR_W-1:0]                 s_address,
    output logic                              s_write,
    output logic                              s_burst,
    output logic [31:0]                       s_wdata,
    output logic [3:0]                        s_wmask,
    input  logic                              s_ready,
    input  logic                              s_rvalid,
    input  logic [31:0]                       s_rdata,
    input  logic                              s_complete
);
    localparam int PTR_W = $clog2(NUM_PORTS);

    arb_state_t           state_reg;
    logic [PTR_W-1:0]     owner_reg;
    logic [PTR_W-1:0]     rr_ptr_reg;
    logic [PTR_W-1:0]     rr_ptr_next;
    logic [NUM_PORTS-1:1] pick_grant;
    logic                 pick_valid;
    logic [PTR_W-1:0]     pick_idx;
    logic [PTR_W-1:0]     grant_idx;
    logic                 grant_any;

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_rr_picker (
        .request (p_request[NUM_PORTS-1:1]),
        .rr_ptr  (rr_ptr_reg),
        .grant   (pick_grant),
        .valid   (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 1; i < NUM_PORTS; i++) begin
            if (pick_grant[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

    assign grant_idx   = p_request[0] ? '0 : pick_idx;
    assign grant_any   = p_request[0] || pick_valid;
    assign rr_ptr_next = (owner_reg == PTR_W'(NUM_PORTS - 1)) ? PTR_W'(1) : owner_reg + PTR_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            owner_reg  <= '0;
            rr_ptr_reg <= PTR_W'(1);
            s_request  <= 1'b0;
            s_address  <= '0;
            s_write    <= 1'b0;
            s_burst    <= 1'b0;
            s_wdata    <= '0;
            s_wmask    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        owner_reg <= grant_idx;
                        s_address <= p_address[grant_idx];
                        s_write   <= p_write[grant_idx];
                        s_burst   <= p_burst[grant_idx];
                        s_wdata   <= p_wdata[grant_idx];
                        s_wmask   <= p_wmask[grant_idx];
                        s_request <= 1'b1;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (s_ready) begin
                        s_request <= 1'b0;
                        // A write may be accepted and finished in one cycle.
                        if (s_complete) begin
                            state_reg <= IDLE;
                            if (owner_reg != '0) begin
                                rr_ptr_reg <= rr_ptr_next;
                            end
                        end else begin
                            state_reg <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (s_complete) begin
                        state_reg <= IDLE;
                        if (owner_reg != '0) begin
                            rr_ptr_reg <= rr_ptr_next;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign p_rdata = s_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic own;
            assign own            = (owner_reg == PTR_W'(gi));
            assign p_ready[gi]    = own && (state_reg == ISSUE) && s_ready;
            assign p_rvalid[gi]   = own && (state_reg == BUSY) && s_rvalid;
            assign p_complete[gi] = own && s_complete &&
                                    ((state_reg == BUSY) || ((state_reg == ISSUE) && s_ready));
        end
    endgenerate
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares the single SDRAM controller port between the VGA scan-out engine and general memory masters such as the CPU data cache and the blitter. Port 0 is reserved for `vga_output` and has absolute priority, so the 64-word display FIFO never underruns. Ports 1..NUM_PORTS-1 are served round-robin. Each requester port uses the same request/ready/complete handshake that `vga_output` already speaks, so the block sits between all masters and the SDRAM controller with no glue logic.

## Interface
- NUM_PORTS, 3, number of requester ports (port 0 = VGA); legal range 2..8
- ADDR_W, 26, byte address width
- clock  in  1  system clock, 125 MHz
- reset  in  1  synchronous, active-high
- p_request  in  [NUM_PORTS]  requester holds high until it sees p_ready
- p_ready  out  [NUM_PORTS]  access accepted; one-cycle pulse
- p_address  in  [NUM_PORTS][ADDR_W]  byte address, word aligned
- p_write  in  [NUM_PORTS]  1 = single-word write, 0 = read
- p_burst  in  [NUM_PORTS]  read only: 1 = 16-word burst, 0 = single word
- p_wdata  in  [NUM_PORTS][32]  write data
- p_wmask  in  [NUM_PORTS][4]  byte enables
- p_rvalid  out  [NUM_PORTS]  read data valid, gated to the owning port
- p_rdata  out  32  read data, broadcast to all ports
- p_complete  out  [NUM_PORTS]  transaction finished; one-cycle pulse
- s_request, s_address[ADDR_W], s_write, s_burst, s_wdata[32], s_wmask[4]  out  command to the SDRAM controller
- s_ready, s_rvalid, s_rdata[32], s_complete  in  responses from the SDRAM controller

## Operation
The arbiter has three states:
- IDLE
  - If any p_request is high, pick a winner. Port 0 wins whenever it requests.
  - Otherwise the first requesting port at or after rr_ptr wins, wrapping within 1..NUM_PORTS-1.
  - Register owner, s_address, s_write, s_burst, s_wdata and s_wmask from the winner. Set s_request=1 and go to ISSUE.
- ISSUE
  - s_ready is forwarded combinationally to p_ready[owner].
  - On s_ready: s_request←0 at the next edge and go to BUSY.
- BUSY
  - p_rvalid[owner]=s_rvalid.
  - p_complete[owner]=s_complete, forwarded combinationally.
  - On s_complete, go to IDLE.
  - If the owner was ≥1, set rr_ptr←owner+1, wrapping NUM_PORTS→1.

Request and routing rules:
- Requests are sampled only in IDLE. A requester that is still high in the cycle after p_ready is never re-granted, because BUSY lasts until complete.
- The command registers are frozen from grant until return to IDLE. Requester inputs may change after p_ready.
- Outside ISSUE, s_ready is ignored and p_ready is 0. Outside BUSY, s_rvalid and s_complete are ignored and all p_rvalid and p_complete are 0.
- If s_ready and s_complete arrive in the same ISSUE cycle (a fast write), forward both, skip BUSY and go directly to IDLE.
- Reset, including mid-operation:
  - State is IDLE, rr_ptr=1.
  - All outputs are 0: s_request, s_write, s_burst, s_address, s_wdata, s_wmask, p_ready, p_rvalid, p_complete. p_rdata tracks s_rdata.
  - Any in-flight transaction is abandoned. The downstream controller is itself reset by the same signal.

## Timing
- Grant latency: a request seen in IDLE at cycle N gives s_request=1 at N+1.
- p_ready, p_rvalid and p_complete have zero added latency (combinational from s_*). p_rdata is a pure wire.
- Minimum spacing: s_complete at cycle N means IDLE at N+1, so the next s_request is at N+2.
- Worst-case VGA wait: one in-flight 16-word burst plus 2 cycles. No fairness counter is applied against port 0.
- Round-robin fairness: with all low-priority ports requesting continuously and port 0 idle, each port is granted once per NUM_PORTS-1 grants.

## Structure
- The shared package `mem_pkg` holds:
  - typedef `arb_state_t` {IDLE, ISSUE, BUSY}
  - BURST_WORDS=16, SDRAM_ADDR_W=26
  - FRAME_BUFFER_START=26'h3f80000
- Sub-module `rr_picker`: combinational; takes the request vector and rr_ptr and produces a one-hot grant plus a valid flag. Port 0 priority lives in the arbiter, not in the picker.

## Test plan
- Port 0 only, burst read at 0x3f80000; the model gives ready at +3 and 16 rvalid beats → p_ready[0] once, 16 p_rvalid[0] beats with matching data, one p_complete[0], other ports silent.
- Ports 0 and 1 raise requests in the same IDLE cycle → port 0 is granted first. Port 1 s_request appears exactly 2 cycles after port 0 completes.
- Ports 1 and 2 request continuously with single-word reads → grants alternate 1,2,1,2, and rr_ptr wraps correctly.
- Port 2 single write, data 0xdeadbeef, mask 4'b0011, with the model returning ready and complete in the same cycle → s_wdata and s_wmask latched, ISSUE→IDLE directly, exactly one p_complete[2].
- Reset asserted at beat 7 of a port 0 burst → next cycle every output is 0 and state is IDLE. Later stray s_rvalid and s_complete produce no p_* pulses.
- Spurious s_ready and s_complete while in IDLE → ignored, no grant change.
